// File: rtl/fft_bin_serializer_if.sv
// Bin stream from fft_bin_serializer to its downstream consumer.
// Valid/ready: a bin transfers on a rising clk edge with bin_valid && bin_ready; once bin_valid
// is high it stays high, and every payload field holds, until that transfer happens.
interface fft_bin_serializer_if #(
   parameter int DW = 16
);
   localparam int MW = DW + 1;

   logic                 bin_valid;
   logic                 bin_ready;
   logic [2:0]           bin_idx;
   logic signed [DW-1:0] bin_re;
   logic signed [DW-1:0] bin_im;
   logic [MW-1:0]        bin_mag;
   logic                 bin_last;

   modport master (
      output bin_valid, bin_idx, bin_re, bin_im, bin_mag, bin_last,
      input  bin_ready
   );

   modport slave (
      input  bin_valid, bin_idx, bin_re, bin_im, bin_mag, bin_last,
      output bin_ready
   );
endinterface

// File: rtl/fft_bin_serializer.sv
// Captures 8-bin FFT frames into a ping-pong store, streams bins with |re|+|im| and tracks the peak bin.
// FFT_PEAK_SKIP_DC_EN: when defined, bin 0 is left out of the peak search.
module fft_bin_serializer #(
   parameter  int DW = 16,
   localparam int MW = DW + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fft_valid,
   input  logic [2*DW-1:0]      fft_d0,
   input  logic [2*DW-1:0]      fft_d1,
   input  logic [2*DW-1:0]      fft_d2,
   input  logic [2*DW-1:0]      fft_d3,
   input  logic [2*DW-1:0]      fft_d4,
   input  logic [2*DW-1:0]      fft_d5,
   input  logic [2*DW-1:0]      fft_d6,
   input  logic [2*DW-1:0]      fft_d7,
   fft_bin_serializer_if.master bin,
   output logic                 peak_valid,
   output logic [2:0]           peak_idx,
   output logic [MW-1:0]        peak_mag,
   output logic                 overrun,
   output logic                 dbg_state
);

   typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

   state_t          state, state_nx;
   logic [2*DW-1:0] fft_d [8];
   logic [2*DW-1:0] mem [2][8];
   logic            fv_q;
   logic [1:0]      full;
   logic            wr_ptr, rd_ptr;
   logic            capture, accept, last_accept, wr_free, cap_ok;

   assign fft_d[0] = fft_d0;
   assign fft_d[1] = fft_d1;
   assign fft_d[2] = fft_d2;
   assign fft_d[3] = fft_d3;
   assign fft_d[4] = fft_d4;
   assign fft_d[5] = fft_d5;
   assign fft_d[6] = fft_d6;
   assign fft_d[7] = fft_d7;

   assign capture     = fft_valid && !fv_q;
   assign accept      = bin.bin_valid && bin.bin_ready;
   assign last_accept = accept && (bin.bin_idx == 3'd7);
   // The write bank equals the read bank only when both are full; it frees as its bin 7 leaves.
   assign wr_free     = !full[wr_ptr] || (last_accept && (rd_ptr == wr_ptr));
   assign cap_ok      = capture && wr_free;
   assign dbg_state   = state;

   always_ff @(posedge clk) begin
      if (cap_ok) begin
         for (int i = 0; i < 8; i++) mem[wr_ptr][i] <= fft_d[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fv_q    <= 1'b1;
         full    <= 2'b00;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         overrun <= 1'b0;
      end else begin
         fv_q <= fft_valid;
         if (last_accept) begin
            full[rd_ptr] <= 1'b0;
            rd_ptr       <= ~rd_ptr;
         end
         if (cap_ok) begin
            full[wr_ptr] <= 1'b1;
            wr_ptr       <= ~wr_ptr;
         end
         if (capture && !wr_free) overrun <= 1'b1;
      end
   end

   // Read FSM: decides which stored word (if any) loads into the output registers.
   logic            ld_en, ld_bank, valid_nx;
   logic [2:0]      ld_addr;

   always_comb begin
      state_nx = state;
      ld_en    = 1'b0;
      ld_bank  = rd_ptr;
      ld_addr  = 3'd0;
      valid_nx = bin.bin_valid;
      case (state)
         IDLE: begin
            if (full[rd_ptr]) begin
               state_nx = STREAM;
               ld_en    = 1'b1;
               valid_nx = 1'b1;
            end
         end
         STREAM: begin
            if (last_accept) begin
               if (full[~rd_ptr]) begin
                  ld_en   = 1'b1;
                  ld_bank = ~rd_ptr;
               end else begin
                  state_nx = IDLE;
                  valid_nx = 1'b0;
               end
            end else if (accept) begin
               ld_en   = 1'b1;
               ld_addr = bin.bin_idx + 3'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   logic [2*DW-1:0] ld_word;
   logic [DW-1:0]   ld_re, ld_im;
   logic [MW-1:0]   re_x, im_x, re_abs, im_abs, ld_mag;

   always_comb begin
      ld_word = mem[ld_bank][ld_addr];
      ld_re   = ld_word[2*DW-1:DW];
      ld_im   = ld_word[DW-1:0];
      re_x    = {ld_re[DW-1], ld_re};
      im_x    = {ld_im[DW-1], ld_im};
      re_abs  = re_x[MW-1] ? (~re_x) + MW'(1) : re_x;
      im_abs  = im_x[MW-1] ? (~im_x) + MW'(1) : im_x;
      ld_mag  = re_abs + im_abs;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         bin.bin_valid <= 1'b0;
         bin.bin_idx   <= 3'd0;
         bin.bin_re    <= '0;
         bin.bin_im    <= '0;
         bin.bin_mag   <= '0;
         bin.bin_last  <= 1'b0;
      end else begin
         state         <= state_nx;
         bin.bin_valid <= valid_nx;
         if (ld_en) begin
            bin.bin_idx  <= ld_addr;
            bin.bin_re   <= ld_re;
            bin.bin_im   <= ld_im;
            bin.bin_mag  <= ld_mag;
            bin.bin_last <= (ld_addr == 3'd7);
         end
      end
   end

`ifdef FFT_PEAK_SKIP_DC_EN
   localparam logic [2:0] FIRST_BIN = 3'd1;
   logic in_search;
   assign in_search = (bin.bin_idx != 3'd0);
`else
   localparam logic [2:0] FIRST_BIN = 3'd0;
   logic in_search;
   assign in_search = 1'b1;
`endif

   logic [2:0]    run_idx, cand_idx;
   logic [MW-1:0] run_mag, cand_mag;

   // Strict greater-than so ties keep the lower index; the first searched bin always seeds.
   always_comb begin
      cand_idx = run_idx;
      cand_mag = run_mag;
      if (in_search && ((bin.bin_idx == FIRST_BIN) || (bin.bin_mag > run_mag))) begin
         cand_idx = bin.bin_idx;
         cand_mag = bin.bin_mag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         run_idx    <= 3'd0;
         run_mag    <= '0;
         peak_valid <= 1'b0;
         peak_idx   <= 3'd0;
         peak_mag   <= '0;
      end else begin
         peak_valid <= last_accept;
         if (accept) begin
            run_idx <= cand_idx;
            run_mag <= cand_mag;
         end
         if (last_accept) begin
            peak_idx <= cand_idx;
            peak_mag <= cand_mag;
         end
      end
   end

endmodule

// File: tb/tb_fft_bin_serializer.sv
// Self-checking bench for fft_bin_serializer: scoreboard of expected bins and peaks, directed scenarios.
module tb_fft_bin_serializer;

   localparam int DW = 16;
   localparam int MW = DW + 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              fft_valid;
   logic [2*DW-1:0]   d [8];
   logic              peak_valid;
   logic [2:0]        peak_idx;
   logic [MW-1:0]     peak_mag;
   logic              overrun;
   logic              dbg_state;

   fft_bin_serializer_if #(.DW(DW)) bin_if ();

   fft_bin_serializer #(.DW(DW)) dut (
      .clk(clk), .rst(rst), .fft_valid(fft_valid),
      .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
      .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
      .bin(bin_if.master),
      .peak_valid(peak_valid), .peak_idx(peak_idx), .peak_mag(peak_mag),
      .overrun(overrun), .dbg_state(dbg_state)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // scoreboard state: {idx, re, im, mag, last} and {peak_idx, peak_mag}
   logic [52:0] exp_q[$];
   logic [19:0] peak_q[$];
   int          acc_cyc[$];
   int          peak_cnt, peak_cyc, hold_cnt, cap_cyc;
   logic [31:0] frm [8];

   function automatic int model_mag(input logic [31:0] w);
      int r, i;
      r = int'($signed(w[31:16]));
      i = int'($signed(w[15:0]));
      return (r < 0 ? -r : r) + (i < 0 ? -i : i);
   endfunction

   function automatic logic [52:0] model_bin(input int k, input logic [31:0] w);
      logic [2:0] idx;
      idx = 3'(k);
      return {idx, w[31:16], w[15:0], 17'(model_mag(w)), (k == 7)};
   endfunction

   task automatic push_frame();
      int first, best_i, best_m, m;
      first = 0;
`ifdef FFT_PEAK_SKIP_DC_EN
      first = 1;
`endif
      best_i = 0;
      best_m = -1;
      for (int k = 0; k < 8; k++) begin
         exp_q.push_back(model_bin(k, frm[k]));
         m = model_mag(frm[k]);
         if (k >= first && m > best_m) begin
            best_m = m;
            best_i = k;
         end
      end
      peak_q.push_back({3'(best_i), 17'(best_m)});
   endtask

   // monitor: outputs sampled on the falling edge
   logic        hold_pending = 1'b0;
   logic [52:0] hold_val;
   always @(negedge clk) begin
      logic [52:0] cur;
      logic [52:0] exp_b;
      if (!rst) begin
         hold_pending = 1'b0;
      end else begin
         cur = {bin_if.bin_idx, bin_if.bin_re, bin_if.bin_im, bin_if.bin_mag, bin_if.bin_last};
         if (hold_pending) begin
            check("hold_valid", bin_if.bin_valid, 1);
            check("hold_stable", cur, hold_val);
         end
         hold_pending = 1'b0;
         if (bin_if.bin_valid) begin
            if (bin_if.bin_ready) begin
               check("bin_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  exp_b = exp_q.pop_front();
                  check("bin", cur, exp_b);
               end
               acc_cyc.push_back(cyc);
            end else begin
               hold_pending = 1'b1;
               hold_val     = cur;
               hold_cnt++;
            end
         end
         if (peak_valid) begin
            peak_cnt++;
            peak_cyc = cyc;
            check("peak_expected", peak_q.size() != 0, 1);
            if (peak_q.size() != 0) check("peak", {peak_idx, peak_mag}, peak_q.pop_front());
         end
      end
   end

   // driver tasks: entered and left at posedge+2
   task automatic drive_frame(input int hold, input bit store);
      for (int k = 0; k < 8; k++) d[k] = frm[k];
      fft_valid = 1'b1;
      cap_cyc   = cyc + 1;
      if (store) push_frame();
      repeat (hold) @(posedge clk);
      #2;
      fft_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
   endtask

   task automatic rand_frame();
      for (int k = 0; k < 8; k++) frm[k] = $urandom_range(32'hFFFF_FFFF, 0);
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 300 && (exp_q.size() != 0 || bin_if.bin_valid); k++) @(posedge clk);
      repeat (3) @(posedge clk);
      #2;
      check({tag, "_drain_bins"}, exp_q.size(), 0);
      check({tag, "_drain_peaks"}, peak_q.size(), 0);
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b1;
   endtask

   function automatic int gap_count();
      int g;
      g = 0;
      for (int i = 1; i < acc_cyc.size(); i++) if (acc_cyc[i] != acc_cyc[i-1] + 1) g++;
      return g;
   endfunction

   initial begin
      int seen_valid, peaks_before, exp_pk;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      // reset
      rst = 1'b1;
      fft_valid = 1'b0;
      bin_if.bin_ready = 1'b1;
      for (int k = 0; k < 8; k++) d[k] = '0;
      #1 rst = 1'b0;
      #2;
      check("rst_bin_valid", bin_if.bin_valid, 0);
      check("rst_bin_last", bin_if.bin_last, 0);
      check("rst_bin_payload", {bin_if.bin_idx, bin_if.bin_re, bin_if.bin_im, bin_if.bin_mag}, 0);
      check("rst_peak", {peak_valid, peak_idx, peak_mag}, 0);
      check("rst_overrun", overrun, 0);
      check("rst_state", dbg_state, 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      #2;

      // single frame, fft_valid high for 3 cycles
      for (int k = 0; k < 8; k++) frm[k] = 32'h0;
      frm[0] = 32'h0003_FFFC;
      frm[5] = 32'h8000_000A;
      acc_cyc.delete();
      peak_cnt = 0;
      drive_frame(3, 1'b1);
      drain("t1");
      check("t1_accepts", acc_cyc.size(), 8);
      if (acc_cyc.size() == 8) check("t1_first_bin_cycle", acc_cyc[0], cap_cyc + 1);
      check("t1_bubbles", gap_count(), 0);
      check("t1_peak_count", peak_cnt, 1);
      check("t1_peak_cycle", peak_cyc, cap_cyc + 9);
      check("t1_peak_idx", peak_idx, 5);
      check("t1_peak_mag", peak_mag, 32778);

      // backpressure 1,0,0,1,...
      rand_frame();
      acc_cyc.delete();
      hold_cnt = 0;
      bin_if.bin_ready = 1'b0;
      drive_frame(1, 1'b1);
      for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
         bin_if.bin_ready = pat[k % 4];
         @(posedge clk);
         #2;
      end
      bin_if.bin_ready = 1'b1;
      drain("t2");
      check("t2_accepts", acc_cyc.size(), 8);
      check("t2_holds_seen", hold_cnt > 0, 1);

      // ping-pong fill, third frame dropped
      bin_if.bin_ready = 1'b0;
      acc_cyc.delete();
      rand_frame();
      drive_frame(2, 1'b1);
      rand_frame();
      drive_frame(2, 1'b1);
      check("t3_no_overrun_yet", overrun, 0);
      rand_frame();
      drive_frame(2, 1'b0);
      check("t3_overrun", overrun, 1);
      bin_if.bin_ready = 1'b1;
      drain("t3");
      check("t3_accepts", acc_cyc.size(), 16);
      check("t3_bubbles", gap_count(), 0);
      check("t3_overrun_sticky", overrun, 1);
      apply_reset();
      #1;
      check("t3_overrun_cleared", overrun, 0);
      repeat (2) @(posedge clk);
      #2;

      // capture coincides with bin 7 acceptance while the other bank is full
      bin_if.bin_ready = 1'b0;
      acc_cyc.delete();
      rand_frame();
      drive_frame(1, 1'b1);
      rand_frame();
      drive_frame(1, 1'b1);
      bin_if.bin_ready = 1'b1;
      repeat (7) @(posedge clk);
      #2;
      check("t4_idx7_at_capture", bin_if.bin_idx, 7);
      rand_frame();
      drive_frame(1, 1'b1);
      drain("t4");
      check("t4_accepts", acc_cyc.size(), 24);
      check("t4_bubbles", gap_count(), 0);
      check("t4_no_overrun", overrun, 0);

      // ties
      for (int k = 0; k < 8; k++) frm[k] = 32'h0001_0001;
      drive_frame(1, 1'b1);
      drain("t5a");
      exp_pk = 0;
`ifdef FFT_PEAK_SKIP_DC_EN
      exp_pk = 1;
`endif
      check("t5_tie_idx", peak_idx, exp_pk);
      check("t5_tie_mag", peak_mag, 2);
      // large DC bin
      frm[0] = 32'h7FFF_0000;
      drive_frame(1, 1'b1);
      drain("t5b");
      check("t5_dc_idx", peak_idx, exp_pk);

      // async reset mid-stream at bin 3, fft_valid held high through it
      rand_frame();
      for (int k = 0; k < 8; k++) d[k] = frm[k];
      for (int k = 0; k < 3; k++) exp_q.push_back(model_bin(k, frm[k]));
      peaks_before = peak_cnt;
      fft_valid = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      check("t6_idx_before_reset", bin_if.bin_idx, 3);
      rst = 1'b0;
      #1;
      check("t6_rst_valid", bin_if.bin_valid, 0);
      check("t6_rst_payload", {bin_if.bin_idx, bin_if.bin_re, bin_if.bin_im, bin_if.bin_mag, bin_if.bin_last}, 0);
      check("t6_rst_peak_valid", peak_valid, 0);
      check("t6_partial_bins", exp_q.size(), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b1;
      seen_valid = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (bin_if.bin_valid) seen_valid++;
      end
      check("t6_no_capture_while_held", seen_valid, 0);
      check("t6_no_peak", peak_cnt, peaks_before);
      @(posedge clk);
      #2 fft_valid = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rand_frame();
      drive_frame(1, 1'b1);
      drain("t6");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
